// File: rtl/frame_sampler.sv
// frame_sampler: reads a 224x224 window of a 1-bit frame buffer in 8-row bands,
// counts white pixels per 8x8 block and emits one thresholded pixel per block
// (28x28 output image) over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start, all outputs quiet
// SCAN   | issuing one frame-buffer read per cycle for the current band
// DRAIN  | two cycles letting the last reads return into the accumulators
// EMIT   | presenting the band's 28 block pixels, block 0 first
// DONE   | one-cycle done pulse before returning to IDLE
module frame_sampler #(
  parameter int COL_NUM   = 320,
  parameter int ROW_NUM   = 240,
  parameter int ORIGIN_X  = 48,
  parameter int ORIGIN_Y  = 8,
  parameter int THRESHOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [16:0] ram_read_addr,
  input  logic        ram_q,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [9:0]  pix_index
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] COL_LAST = 8'd223;
  localparam logic [2:0] ROW_LAST = 3'd7;
  localparam logic [4:0] IDX_LAST = 5'd27;
  localparam logic [6:0] THR      = 7'(THRESHOLD);

  // A misplaced window would silently read outside the frame buffer.
  if (ORIGIN_X + 224 > COL_NUM || ORIGIN_Y + 224 > ROW_NUM) begin : g_region_check
    $error("frame_sampler: sampled region does not fit in the frame buffer");
  end

  state_t      state_q;
  logic [4:0]  band_q;
  logic [2:0]  row_q;
  logic [7:0]  col_q;
  logic [4:0]  blk_q;
  logic        drain_q;
  logic        p1_vld_q, p2_vld_q;
  logic [4:0]  p1_blk_q, p2_blk_q;
  logic [6:0]  acc_q [28];

  logic [7:0]  col_d;
  logic [2:0]  row_d;
  logic [4:0]  blk_d;
  logic        scan_last;

  // Frame-buffer address of window pixel (band, row-in-band, column).
  function automatic logic [16:0] addr_of(input logic [4:0] b, input logic [2:0] r,
                                          input logic [7:0] c);
    return 17'((32'(ORIGIN_Y) + 32'(b) * 32'd8 + 32'(r)) * 32'(COL_NUM)
               + 32'(ORIGIN_X) + 32'(c));
  endfunction

  // Output pixel index of block k in band b.
  function automatic logic [9:0] idx_of(input logic [4:0] b, input logic [4:0] k);
    return 10'(b) * 10'd28 + 10'(k);
  endfunction

  // Next scan position: column runs fastest, then row within the band.
  always_comb begin
    scan_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    blk_d     = blk_q + 5'd1;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + 3'd1;
    end else begin
      col_d = col_q + 8'd1;
      row_d = row_q;
    end
  end

  // Sequencer, read-tracking pipeline, block accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_read_addr <= '0;
      pix_valid     <= 1'b0;
      pix_data      <= 1'b0;
      pix_index     <= '0;
      band_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      blk_q         <= '0;
      drain_q       <= 1'b0;
      p1_vld_q      <= 1'b0;
      p2_vld_q      <= 1'b0;
      p1_blk_q      <= '0;
      p2_blk_q      <= '0;
      for (int i = 0; i < 28; i++) acc_q[i] <= '0;
    end else begin
      // Reads return two cycles after issue; the pipeline remembers their block.
      p1_vld_q <= (state_q == S_SCAN);
      p1_blk_q <= col_q[7:3];
      p2_vld_q <= p1_vld_q;
      p2_blk_q <= p1_blk_q;
      if (p2_vld_q) acc_q[p2_blk_q] <= acc_q[p2_blk_q] + 7'(ram_q);
      done <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_SCAN;
            busy          <= 1'b1;
            band_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            ram_read_addr <= addr_of(5'd0, 3'd0, 8'd0);
          end
        end
        S_SCAN: begin
          if (scan_last) begin
            state_q       <= S_DRAIN;
            drain_q       <= 1'b0;
            ram_read_addr <= '0;
          end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            ram_read_addr <= addr_of(band_q, row_d, col_d);
          end
        end
        S_DRAIN: begin
          // Block 0 finished long before the last read, so it is safe to present now.
          if (drain_q) begin
            state_q   <= S_EMIT;
            blk_q     <= '0;
            pix_valid <= 1'b1;
            pix_data  <= (acc_q[0] >= THR);
            pix_index <= idx_of(band_q, 5'd0);
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            if (blk_q == IDX_LAST) begin
              pix_valid <= 1'b0;
              pix_data  <= 1'b0;
              pix_index <= '0;
              for (int i = 0; i < 28; i++) acc_q[i] <= '0;
              if (band_q == IDX_LAST) begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end else begin
                state_q       <= S_SCAN;
                band_q        <= band_q + 5'd1;
                row_q         <= '0;
                col_q         <= '0;
                ram_read_addr <= addr_of(band_q + 5'd1, 3'd0, 8'd0);
              end
            end else begin
              blk_q     <= blk_d;
              pix_data  <= (acc_q[blk_d] >= THR);
              pix_index <= pix_index + 10'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          busy          <= 1'b0;
          pix_valid     <= 1'b0;
          pix_data      <= 1'b0;
          pix_index     <= '0;
          ram_read_addr <= '0;
        end
      endcase
    end
  end

endmodule
